// File: rtl/button_pkg.sv
// Shared types and defaults for the Mode/Trip pin conditioning front-end.
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btn_state_t;

   localparam int DEBOUNCE_DEFAULT = 900;
   localparam int HOLD_DEFAULT     = 72000;

   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/button_filter.sv
// One button channel: 2-flop synchroniser, debounce FSM, saturating hold timer.
//   state        | meaning
//   RELEASED     | clean = 1, waiting for synced pin to go low
//   PRESS_PEND   | pin low, counting toward press acceptance
//   PRESSED      | clean = 0, hold timer running
//   RELEASE_PEND | pin high, counting toward release acceptance
module button_filter
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_clean,
   output logic o_press,
   output logic o_hold
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

   logic          r_s1;
   logic          r_s2;
   btn_state_t    r_state;
   logic [DW-1:0] r_cnt;
   logic [HW-1:0] r_hold_cnt;
   logic          r_clean;
   logic          r_press;
   logic          r_hold;

   btn_state_t    w_state_nxt;
   logic [DW-1:0] w_cnt_nxt;
   logic [HW-1:0] w_hold_cnt_nxt;
   logic [HW-1:0] w_hold_inc;
   logic          w_clean_nxt;
   logic          w_press_nxt;
   logic          w_hold_nxt;

   assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1       <= 1'b1;
         r_s2       <= 1'b1;
         r_state    <= RELEASED;
         r_cnt      <= '0;
         r_hold_cnt <= '0;
         r_clean    <= 1'b1;
         r_press    <= 1'b0;
         r_hold     <= 1'b0;
      end else begin
         r_s1       <= i_raw;
         r_s2       <= r_s1;
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_clean    <= w_clean_nxt;
         r_press    <= w_press_nxt;
         r_hold     <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_hold_cnt_nxt = r_hold_cnt;
      w_clean_nxt    = r_clean;
      w_press_nxt    = 1'b0;
      w_hold_nxt     = r_hold;
      case (r_state)
         RELEASED: begin
            if (!r_s2) begin
               w_state_nxt = PRESS_PEND;
               w_cnt_nxt   = DW'(1);
            end
         end
         PRESS_PEND: begin
            if (r_s2) begin
               w_state_nxt = RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_nxt    = PRESSED;
               w_cnt_nxt      = '0;
               w_clean_nxt    = 1'b0;
               w_press_nxt    = 1'b1;
               w_hold_cnt_nxt = '0;
               w_hold_nxt     = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + DW'(1);
            end
         end
         PRESSED: begin
            w_hold_cnt_nxt = w_hold_inc;
            w_hold_nxt     = r_hold | (w_hold_inc == HOLD_MAX);
            if (r_s2) begin
               w_state_nxt = RELEASE_PEND;
               w_cnt_nxt   = DW'(1);
            end
         end
         RELEASE_PEND: begin
            w_hold_cnt_nxt = w_hold_inc;
            w_hold_nxt     = r_hold | (w_hold_inc == HOLD_MAX);
            if (!r_s2) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               // release wins over the hold timer on the accepting edge
               w_state_nxt    = RELEASED;
               w_cnt_nxt      = '0;
               w_clean_nxt    = 1'b1;
               w_hold_nxt     = 1'b0;
               w_hold_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + DW'(1);
            end
         end
         default: begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_clean = r_clean;
   assign o_press = r_press;
   assign o_hold  = r_hold;

endmodule

// File: rtl/button_conditioner.sv
// Pin-side conditioning of the raw Mode and Trip buttons feeding button_manager.
module button_conditioner
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic Mode_Raw,
   input  logic Trip_Raw,
   output logic Mode,
   output logic Trip,
   output logic Mode_Press,
   output logic Trip_Press,
   output logic Mode_Hold,
   output logic Trip_Hold
);

   button_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
   ) u_mode (
      .i_clk   (HCLK),
      .i_rst_n (HRESETn),
      .i_raw   (Mode_Raw),
      .o_clean (Mode),
      .o_press (Mode_Press),
      .o_hold  (Mode_Hold)
   );

   button_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
   ) u_trip (
      .i_clk   (HCLK),
      .i_rst_n (HRESETn),
      .i_raw   (Trip_Raw),
      .o_clean (Trip),
      .o_press (Trip_Press),
      .o_hold  (Trip_Hold)
   );

endmodule
